// File: rtl/tdm_demux4.sv
// Receive-side 4-slot TDM demultiplexer: collects one sample per slot behind a slot-0
// frame sync and publishes all four channels together once the frame is complete.
module tdm_demux4 #(
    parameter int DW = 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [DW-1:0]   din_i,
    input  logic            din_vld_i,
    input  logic            fsync_i,
    output logic [4*DW-1:0] dout_o,
    output logic            dout_vld_o,
    output logic [1:0]      slot_o,
    output logic            locked_o,
    output logic            sync_err_o
);

    // state  | meaning
    // HUNT   | waiting for an accepted sample with fsync to start a frame
    // LOCKED | framing established; slot_q is the next expected slot
    typedef enum logic {
        ST_HUNT   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [1:0]      slot_q, slot_d;
    logic [DW-1:0]   hold0_q, hold0_d;
    logic [DW-1:0]   hold1_q, hold1_d;
    logic [DW-1:0]   hold2_q, hold2_d;
    logic [4*DW-1:0] dout_q, dout_d;
    logic            dout_vld_q, dout_vld_d;
    logic            sync_err_q, sync_err_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_HUNT;
            slot_q     <= 2'd0;
            hold0_q    <= '0;
            hold1_q    <= '0;
            hold2_q    <= '0;
            dout_q     <= '0;
            dout_vld_q <= 1'b0;
            sync_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            slot_q     <= slot_d;
            hold0_q    <= hold0_d;
            hold1_q    <= hold1_d;
            hold2_q    <= hold2_d;
            dout_q     <= dout_d;
            dout_vld_q <= dout_vld_d;
            sync_err_q <= sync_err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        slot_d     = slot_q;
        hold0_d    = hold0_q;
        hold1_d    = hold1_q;
        hold2_d    = hold2_q;
        dout_d     = dout_q;
        dout_vld_d = 1'b0;
        sync_err_d = 1'b0;

        if (din_vld_i) begin
            case (state_q)
                ST_HUNT: begin
                    if (fsync_i) begin
                        hold0_d = din_i;
                        slot_d  = 2'd1;
                        state_d = ST_LOCKED;
                    end
                end
                ST_LOCKED: begin
                    if (slot_q == 2'd0) begin
                        if (fsync_i) begin
                            hold0_d = din_i;
                            slot_d  = 2'd1;
                        end else begin
                            sync_err_d = 1'b1;
                            slot_d     = 2'd0;
                            state_d    = ST_HUNT;
                        end
                    end else if (fsync_i) begin
                        // Early sync restarts the frame with this sample as slot 0.
                        sync_err_d = 1'b1;
                        hold0_d    = din_i;
                        slot_d     = 2'd1;
                    end else begin
                        case (slot_q)
                            2'd1: begin
                                hold1_d = din_i;
                                slot_d  = 2'd2;
                            end
                            2'd2: begin
                                hold2_d = din_i;
                                slot_d  = 2'd3;
                            end
                            default: begin
                                dout_d     = {din_i, hold2_q, hold1_q, hold0_q};
                                dout_vld_d = 1'b1;
                                slot_d     = 2'd0;
                            end
                        endcase
                    end
                end
                default: begin
                    state_d = ST_HUNT;
                    slot_d  = 2'd0;
                end
            endcase
        end
    end

    assign dout_o     = dout_q;
    assign dout_vld_o = dout_vld_q;
    assign slot_o     = slot_q;
    assign locked_o   = (state_q == ST_LOCKED);
    assign sync_err_o = sync_err_q;

endmodule

// File: tb/tb_tdm_demux4.sv
// Scoreboard bench for tdm_demux4: stimulus pushes expected frames, a negedge monitor
// pops and compares them whenever dout_vld is seen.
module tb_tdm_demux4;

    localparam int DW = 1;

    logic            clk = 1'b0;
    logic            rst;
    logic [DW-1:0]   din;
    logic            din_vld;
    logic            fsync;
    logic [4*DW-1:0] dout;
    logic            dout_vld;
    logic [1:0]      slot;
    logic            locked;
    logic            sync_err;

    int checks  = 0;
    int errors  = 0;
    int vld_cnt = 0;
    int err_cnt = 0;
    logic [4*DW-1:0] exp_q[$];

    tdm_demux4 #(.DW(DW)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .din_i      (din),
        .din_vld_i  (din_vld),
        .fsync_i    (fsync),
        .dout_o     (dout),
        .dout_vld_o (dout_vld),
        .slot_o     (slot),
        .locked_o   (locked),
        .sync_err_o (sync_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (dout_vld === 1'b1) begin
            vld_cnt++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_dout_vld: got dout %0h expected no frame", dout);
            end else begin
                check("dout_frame", 32'(dout), 32'(exp_q.pop_front()));
            end
        end
        if (sync_err === 1'b1) err_cnt++;
    end

    task automatic drive(input logic v, input logic [DW-1:0] d, input logic f);
        @(negedge clk);
        din_vld = v;
        din     = d;
        fsync   = f;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, DW'($urandom), 1'($urandom));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst     = 1'b1;
        din_vld = 1'b1;
        fsync   = 1'b1;
        din     = DW'($urandom);
        @(negedge clk);
        rst     = 1'b0;
        din_vld = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_dout"},     32'(dout),     32'd0);
        check({tag, "_dout_vld"}, 32'(dout_vld), 32'd0);
        check({tag, "_locked"},   32'(locked),   32'd0);
        check({tag, "_slot"},     32'(slot),     32'd0);
        check({tag, "_sync_err"}, 32'(sync_err), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Test 1: reset held two cycles with random inputs
        rst     = 1'b1;
        din_vld = 1'($urandom);
        din     = DW'($urandom);
        fsync   = 1'($urandom);
        repeat (2) begin
            @(negedge clk);
            din_vld = 1'($urandom);
            din     = DW'($urandom);
            fsync   = 1'($urandom);
        end
        @(negedge clk);
        rst     = 1'b0;
        din_vld = 1'b0;
        check_reset_outputs("t1");

        // Test 2: back-to-back frame 1,0,0,1
        exp_q.push_back(4'b1001);
        drive(1'b1, 1'b1, 1'b1);
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0);
        idle(1);
        check("t2_dout_vld", 32'(dout_vld), 32'd1);
        check("t2_locked",   32'(locked),   32'd1);
        check("t2_slot",     32'(slot),     32'd0);
        idle(2);
        check("t2_vld_pulse", 32'(dout_vld), 32'd0);
        check("t2_vld_cnt",   32'(vld_cnt),  32'd1);

        // Test 3: same frame with idle gaps; slot must hold
        exp_q.push_back(4'b1001);
        drive(1'b1, 1'b1, 1'b1);
        idle(1);
        check("t3_slot_gap1", 32'(slot), 32'd1);
        idle(2);
        check("t3_slot_gap1_end", 32'(slot), 32'd1);
        drive(1'b1, 1'b0, 1'b0);
        idle(1);
        check("t3_slot_gap2", 32'(slot), 32'd2);
        idle(2);
        drive(1'b1, 1'b0, 1'b0);
        idle(3);
        check("t3_slot_gap3", 32'(slot), 32'd3);
        check("t3_no_vld_yet", 32'(vld_cnt), 32'd1);
        drive(1'b1, 1'b1, 1'b0);
        idle(4);
        check("t3_vld_cnt", 32'(vld_cnt), 32'd2);
        check("t3_dout_hold", 32'(dout), 32'b1001);

        // Test 4: HUNT drops non-sync samples
        do_reset();
        check("t4_rst_dout", 32'(dout), 32'd0);
        repeat (5) drive(1'b1, DW'($urandom), 1'b0);
        idle(1);
        check("t4_hunt_locked", 32'(locked), 32'd0);
        check("t4_hunt_slot",   32'(slot),   32'd0);
        exp_q.push_back(4'b0110);
        drive(1'b1, 1'b0, 1'b1);
        idle(1);
        check("t4_lock_rise", 32'(locked), 32'd1);
        check("t4_lock_slot", 32'(slot),   32'd1);
        drive(1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b0);
        idle(3);
        check("t4_vld_cnt", 32'(vld_cnt), 32'd3);

        // Test 5: early sync at slot 2, then frame 1,0,1,0
        exp_q.push_back(4'b0101);
        drive(1'b1, 1'b1, 1'b1);
        drive(1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b1);
        idle(1);
        check("t5_sync_err", 32'(sync_err), 32'd1);
        check("t5_locked",   32'(locked),   32'd1);
        check("t5_slot",     32'(slot),     32'd1);
        idle(1);
        check("t5_err_pulse", 32'(sync_err), 32'd0);
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b0);
        idle(3);
        check("t5_err_cnt", 32'(err_cnt), 32'd1);
        check("t5_vld_cnt", 32'(vld_cnt), 32'd4);
        check("t5_dout",    32'(dout),    32'b0101);

        // Test 6: missing sync drops lock, then reset mid-frame
        exp_q.push_back(4'b0011);
        drive(1'b1, 1'b1, 1'b1);
        drive(1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0);
        idle(1);
        drive(1'b1, 1'b1, 1'b0);
        idle(1);
        check("t6_sync_err", 32'(sync_err), 32'd1);
        check("t6_locked",   32'(locked),   32'd0);
        check("t6_slot",     32'(slot),     32'd0);
        idle(1);
        check("t6_err_pulse", 32'(sync_err), 32'd0);
        check("t6_dout_hold", 32'(dout),     32'b0011);
        drive(1'b1, 1'b0, 1'b1);
        drive(1'b1, 1'b1, 1'b0);
        idle(1);
        check("t6_partial_slot", 32'(slot), 32'd2);
        do_reset();
        check_reset_outputs("t6_rst");
        exp_q.push_back(4'b1101);
        drive(1'b1, 1'b1, 1'b1);
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b0);
        idle(3);
        check("t6_vld_cnt",  32'(vld_cnt),      32'd6);
        check("t6_err_cnt",  32'(err_cnt),      32'd2);
        check("t6_exp_left", 32'(exp_q.size()), 32'd0);
        check("t6_locked_end", 32'(locked),     32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
